video_top: RTL and testbench

Top level of the video controller. It generates VGA-style timing and a grid test pattern on a video interface, drives the board LEDs, and runs entirely from the 50 MHz board clock, which is also the pixel clock. Board push-button KEY[0] is the system reset. The hardware-support interface is present for board integration and is not used functionally.

---
 rtl/video_top_if.sv | 19 +
 rtl/video_top.sv | 116 +++++++++++
 tb/tb_video_top.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/video_top_if.sv
// Video stream and hardware-support bus interfaces for the video controller.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;
  modport master (output CLK, HS, VS, BLANK, RGB);
  modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

interface hws_if;
  logic [15:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  modport master (output address, read, write, writedata);
  modport slave  (input  address, read, write, writedata);
endinterface

// File: rtl/video_top.sv
// Video controller top: reset synchroniser, VGA-style timing with a 16-pixel
// white grid test pattern, and board status LEDs.
module video_top #(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int HFP        = 40,
  parameter int HPULSE     = 48,
  parameter int HBP        = 40,
  parameter int VFP        = 13,
  parameter int VPULSE     = 3,
  parameter int VBP        = 29,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic       FPGA_CLK1_50,
  input  logic [1:0] KEY,
  output logic [7:0] LED,
  input  logic [3:0] SW,
  video_if.master    video_ifm,
  hws_if.master      hws_ifm
);
  localparam int HTOT = HDISP + HFP + HPULSE + HBP;
  localparam int VTOT = VDISP + VFP + VPULSE + VBP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);
  localparam int BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic clk;
  logic key_rst_n;
  logic unused_key;
  assign clk        = FPGA_CLK1_50;
  assign key_rst_n  = KEY[0];
  assign unused_key = KEY[1];

  // Asynchronous assert, synchronous two-stage release of the internal reset.
  logic [1:0] rst_sync_reg;
  logic       rst_n;
  always_ff @(posedge clk or negedge key_rst_n) begin
    if (!key_rst_n) rst_sync_reg <= 2'b00;
    else            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          hlast;
  logic          vlast;
  assign hlast = (hcnt == HW'(HTOT - 1));
  assign vlast = (vcnt == VW'(VTOT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= hlast ? '0 : hcnt + 1'b1;
      if (hlast) vcnt <= vlast ? '0 : vcnt + 1'b1;
    end
  end

  logic        blank_next;
  logic        hs_next;
  logic        vs_next;
  logic [23:0] rgb_next;
  always_comb begin
    blank_next = (hcnt < HW'(HDISP)) && (vcnt < VW'(VDISP));
    hs_next    = !((hcnt >= HW'(HDISP + HFP)) && (hcnt < HW'(HDISP + HFP + HPULSE)));
    vs_next    = !((vcnt >= VW'(VDISP + VFP)) && (vcnt < VW'(VDISP + VFP + VPULSE)));
    rgb_next   = (blank_next && (hcnt[3:0] == 4'd0 || vcnt[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h000000;
  end

  // Decoded outputs are registered so all four stay aligned one clock behind the counters.
  logic        blank_reg;
  logic        hs_reg;
  logic        vs_reg;
  logic [23:0] rgb_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_reg <= 1'b0;
      hs_reg    <= 1'b1;
      vs_reg    <= 1'b1;
      rgb_reg   <= 24'h000000;
    end else begin
      blank_reg <= blank_next;
      hs_reg    <= hs_next;
      vs_reg    <= vs_next;
      rgb_reg   <= rgb_next;
    end
  end

  logic [BW-1:0] blink_cnt;
  logic          led1_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      led1_reg  <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      led1_reg  <= ~led1_reg;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign LED = {2'b00, SW, led1_reg, KEY[0]};

  assign video_ifm.CLK   = FPGA_CLK1_50;
  assign video_ifm.HS    = hs_reg;
  assign video_ifm.VS    = vs_reg;
  assign video_ifm.BLANK = blank_reg;
  assign video_ifm.RGB   = rgb_reg;

  assign hws_ifm.address   = '0;
  assign hws_ifm.read      = 1'b0;
  assign hws_ifm.write     = 1'b0;
  assign hws_ifm.writedata = '0;
endmodule

// File: tb/tb_video_top.sv
// Bench for video_top: reference model derives expected video/LED state from
// elapsed cycles since reset release.
module tb_video_top;
  localparam int HD = 160, VD = 90, HF = 40, HP = 48, HB = 40;
  localparam int VF = 13, VP = 3, VB = 29, BH = 10;
  localparam int HT    = HD + HF + HP + HB;
  localparam int VT    = VD + VF + VP + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic [1:0] key;
  logic [3:0] sw;
  logic [7:0] led;

  video_if vif();
  hws_if   hif();

  video_top #(
    .HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VFP(VF), .VPULSE(VP), .VBP(VB), .BLINK_HALF(BH)
  ) dut (
    .FPGA_CLK1_50(clk),
    .KEY(key),
    .LED(led),
    .SW(sw),
    .video_ifm(vif),
    .hws_ifm(hif)
  );

  always #10 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      if (miscompares <= 40)
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string ph);
    check({ph, ".hs"},    32'(vif.HS),    32'd1);
    check({ph, ".vs"},    32'(vif.VS),    32'd1);
    check({ph, ".blank"}, 32'(vif.BLANK), 32'd0);
    check({ph, ".rgb"},   32'(vif.RGB),   32'd0);
    check({ph, ".led1"},  32'(led[1]),    32'd0);
    check({ph, ".led0"},  32'(led[0]),    32'(key[0]));
  endtask

  // Expected outputs n cycles after the first counting edge, from raster position.
  task automatic check_model(input int n, input string ph);
    int p, h, v;
    logic b, hs, vs, l1;
    logic [23:0] rgb;
    p   = n % FRAME;
    h   = p % HT;
    v   = p / HT;
    b   = (h < HD) && (v < VD);
    hs  = !((h >= HD + HF) && (h < HD + HF + HP));
    vs  = !((v >= VD + VF) && (v < VD + VF + VP));
    rgb = (b && ((h % 16) == 0 || (v % 16) == 0)) ? 24'hFFFFFF : 24'h000000;
    l1  = (((n + 1) / BH) % 2) == 1;
    check({ph, ".blank"}, 32'(vif.BLANK), 32'(b));
    check({ph, ".hs"},    32'(vif.HS),    32'(hs));
    check({ph, ".vs"},    32'(vif.VS),    32'(vs));
    check({ph, ".rgb"},   32'(vif.RGB),   32'(rgb));
    check({ph, ".led1"},  32'(led[1]),    32'(l1));
    check({ph, ".led0"},  32'(led[0]),    32'(key[0]));
    check({ph, ".sw"},    32'(led[7:2]),  32'({2'b00, sw}));
  endtask

  // Release KEY[0] between edges; two edges of synchroniser latency, then the raster runs.
  task automatic release_and_run(input int ncycles, input string ph);
    int hs_fall, vs_fall, vs_prev_fall, blank_rise_cyc;
    logic hs_prev, vs_prev;
    key[0] = 1'b1;
    #1;
    check({ph, ".led0_rise"}, 32'(led[0]), 32'd1);
    tick();
    check_reset_state({ph, ".sync1"});
    tick();
    check_reset_state({ph, ".sync2"});
    blank_rise_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      if (vif.BLANK !== 1'b1) begin
        tick();
        blank_rise_cyc++;
      end
    end
    check({ph, ".blank_rise_clocks"}, 32'(blank_rise_cyc), 32'd1);
    hs_prev = 1'b1; vs_prev = 1'b1;
    hs_fall = -1; vs_fall = -1; vs_prev_fall = -1;
    for (int n = 0; n < ncycles; n++) begin
      if (n > 0) tick();
      if ((n % 64) == 0) begin
        sw = 4'($urandom);
        #1;
      end
      check_model(n, ph);
      if (hs_prev && !vif.HS) hs_fall = n;
      if (!hs_prev && vif.HS && hs_fall >= 0) check({ph, ".hs_low_len"}, 32'(n - hs_fall), 32'(HP));
      if (vs_prev && !vif.VS) begin
        if (vs_prev_fall >= 0) check({ph, ".vs_period"}, 32'(n - vs_prev_fall), 32'(FRAME));
        vs_prev_fall = n;
        vs_fall      = n;
      end
      if (!vs_prev && vif.VS && vs_fall >= 0) begin
        check({ph, ".vs_low_len"}, 32'(n - vs_fall), 32'(VP * HT));
        $display("%s: VS pulse at cycle %0d, low %0d cycles", ph, vs_fall, n - vs_fall);
      end
      hs_prev = vif.HS;
      vs_prev = vif.VS;
    end
    $display("%s: ran %0d cycles, vectors=%0d", ph, ncycles, vectors);
  endtask

  initial begin
    int gap, hold;
    key = 2'b11;
    sw  = 4'b0000;
    #5;
    check("init.led0", 32'(led[0]), 32'd1);
    #20;
    key[0] = 1'b0;
    #1;
    check("init.led0_fall", 32'(led[0]), 32'd0);
    #127;
    check_reset_state("init.hold");
    tick();
    check_reset_state("init.hold_edge");
    #3;

    release_and_run(2 * FRAME + 1000, "run1");

    // Mid-frame asynchronous reset.
    gap = $urandom_range(2, 15);
    #(gap);
    key[0] = 1'b0;
    #1;
    check_reset_state("midreset.async");
    hold = $urandom_range(40, 200);
    #(hold);
    check_reset_state("midreset.hold");
    $display("midreset: KEY[0] low for %0d ns", hold + 1);
    release_and_run(700, "run2");

    sw = 4'b1010;
    #1;
    check("sw1010.led52", 32'(led[5:2]), 32'hA);
    check("sw1010.led76", 32'(led[7:6]), 32'h0);
    check("hws.address",   32'(hif.address),   32'h0);
    check("hws.read",      32'(hif.read),      32'h0);
    check("hws.write",     32'(hif.write),     32'h0);
    check("hws.writedata", 32'(hif.writedata), 32'h0);
    tick();
    check("vclk.high", 32'(vif.CLK), 32'(clk));
    #10;
    check("vclk.low", 32'(vif.CLK), 32'(clk));
    $display("static: SW=1010 LED=%b", led);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
